// File: rtl/wb_select_stage.sv
// Registered writeback-select stage: picks register-file write data from NSRC
// source buses, registers it with rd/we, handles stall/flush, flags bad selects.
module wb_select_stage #(
   parameter int WIDTH      = 32,
   parameter int NSRC       = 3,
   parameter int SEL_ONEHOT = 0,
   parameter int SELW       = 2,
   parameter int RADDR      = 5,
   parameter int ZERO_GUARD = 1,
   parameter int ERRW       = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic                  in_valid,
   input  logic [SELW-1:0]       in_sel,
   input  logic [RADDR-1:0]      in_rd,
   input  logic                  in_regwrite,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [RADDR-1:0]      fwd_rs,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      wb_data,
   output logic [RADDR-1:0]      wb_rd,
   output logic                  wb_we,
   output logic                  fwd_hit,
   output logic                  sel_err,
   output logic [ERRW-1:0]       err_count
);

   logic [NSRC-1:0]  sel_match;
   logic             sel_legal;
   logic [WIDTH-1:0] sel_data;
   logic             rd_guarded;

   logic             valid_q,   valid_d;
   logic [WIDTH-1:0] data_q,    data_d;
   logic [RADDR-1:0] rd_q,      rd_d;
   logic             we_q,      we_d;
   logic             sel_err_q, sel_err_d;
   logic [ERRW-1:0]  err_cnt_q, err_cnt_d;

   // Each source has its own match term; an all-zero one-hot select is the
   // legacy "normal" encoding and maps onto source 0.
   always_comb begin
      sel_match = '0;
      sel_legal = 1'b0;
      sel_data  = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (SEL_ONEHOT != 0)
            sel_match[k] = (in_sel == (SELW'(1) << k)) || ((k == 0) && (in_sel == '0));
         else
            sel_match[k] = (in_sel == SELW'(k));
         if (sel_match[k]) begin
            sel_legal = 1'b1;
            sel_data  = src_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign rd_guarded = (ZERO_GUARD != 0) && (in_rd == '0);

   // NOTE: every next-state signal gets a default at the top of the block so
   // that no path through the if/else chain leaves it unassigned (no latches).
   always_comb begin
      valid_d   = valid_q;
      data_d    = data_q;
      rd_d      = rd_q;
      we_d      = we_q;
      sel_err_d = 1'b0;
      err_cnt_d = err_cnt_q;
      if (flush) begin
         valid_d = 1'b0;
         we_d    = 1'b0;
      end else if (!stall) begin
         valid_d = in_valid;
         rd_d    = in_rd;
         if (sel_legal) begin
            data_d = sel_data;
            we_d   = in_valid & in_regwrite & ~rd_guarded;
         end else begin
            we_d = 1'b0;
            if (in_valid) begin
               sel_err_d = 1'b1;
               if (err_cnt_q != '1)
                  err_cnt_d = err_cnt_q + 1'b1;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         rd_q      <= '0;
         we_q      <= 1'b0;
         sel_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         valid_q   <= valid_d;
         data_q    <= data_d;
         rd_q      <= rd_d;
         we_q      <= we_d;
         sel_err_q <= sel_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign wb_data   = data_q;
   assign wb_rd     = rd_q;
   assign wb_we     = we_q;
   assign sel_err   = sel_err_q;
   assign err_count = err_cnt_q;
   assign fwd_hit   = valid_q & we_q & (rd_q == fwd_rs) & ~((ZERO_GUARD != 0) && (fwd_rs == '0));

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: a binary-select and a one-hot-select instance
// share stimulus and are checked against a behavioural model.
module tb_wb_select_stage;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_regwrite, stall, flush;
   logic [31:0] src [3];
   logic [95:0] src_data;
   logic [1:0]  in_sel_a;
   logic [2:0]  in_sel_b;
   logic [4:0]  in_rd, fwd_rs;

   logic        out_valid_a, wb_we_a, fwd_hit_a, sel_err_a;
   logic [31:0] wb_data_a;
   logic [4:0]  wb_rd_a;
   logic [7:0]  err_count_a;
   logic        out_valid_b, wb_we_b, fwd_hit_b, sel_err_b;
   logic [31:0] wb_data_b;
   logic [4:0]  wb_rd_b;
   logic [7:0]  err_count_b;

   int n_checks = 0;
   int n_pass   = 0;

   assign src_data = {src[2], src[1], src[0]};
   always #5 clk = ~clk;

   wb_select_stage #(.WIDTH(32), .NSRC(3), .SEL_ONEHOT(0), .SELW(2), .RADDR(5),
                     .ZERO_GUARD(1), .ERRW(8)) dut_a (
      .clk(clk), .reset(reset), .src_data(src_data), .in_valid(in_valid),
      .in_sel(in_sel_a), .in_rd(in_rd), .in_regwrite(in_regwrite), .stall(stall),
      .flush(flush), .fwd_rs(fwd_rs), .out_valid(out_valid_a), .wb_data(wb_data_a),
      .wb_rd(wb_rd_a), .wb_we(wb_we_a), .fwd_hit(fwd_hit_a), .sel_err(sel_err_a),
      .err_count(err_count_a));

   wb_select_stage #(.WIDTH(32), .NSRC(3), .SEL_ONEHOT(1), .SELW(3), .RADDR(5),
                     .ZERO_GUARD(1), .ERRW(8)) dut_b (
      .clk(clk), .reset(reset), .src_data(src_data), .in_valid(in_valid),
      .in_sel(in_sel_b), .in_rd(in_rd), .in_regwrite(in_regwrite), .stall(stall),
      .flush(flush), .fwd_rs(fwd_rs), .out_valid(out_valid_b), .wb_data(wb_data_b),
      .wb_rd(wb_rd_b), .wb_we(wb_we_b), .fwd_hit(fwd_hit_b), .sel_err(sel_err_b),
      .err_count(err_count_b));

   typedef struct {
      bit          v;
      bit [31:0]   d;
      bit [4:0]    rd;
      bit          we;
      bit          err;
      int          cnt;
   } mstate_t;

   mstate_t ma, mb;

   // Behavioural rules: decide legality/index arithmetically, then apply priority.
   function automatic mstate_t mstep(mstate_t s, int sel, bit onehot);
      mstate_t n = s;
      bit legal;
      int idx;
      n.err = 0;
      if (reset) begin
         n.v = 0; n.d = 0; n.rd = 0; n.we = 0; n.cnt = 0;
      end else if (flush) begin
         n.v = 0; n.we = 0;
      end else if (!stall) begin
         if (onehot) begin
            legal = ($countones(sel) <= 1);
            idx   = (sel == 0) ? 0 : $clog2(sel);
         end else begin
            legal = (sel < 3);
            idx   = sel;
         end
         n.v  = in_valid;
         n.rd = in_rd;
         if (legal) begin
            n.d  = src[idx];
            n.we = in_valid && in_regwrite && (in_rd != 0);
         end else begin
            n.we = 0;
            if (in_valid) begin
               n.err = 1;
               n.cnt = (s.cnt >= 255) ? 255 : s.cnt + 1;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [48:0] exp_of(mstate_t s);
      bit hit = s.v && s.we && (s.rd == fwd_rs) && (fwd_rs != 0);
      return {s.v, s.d, s.rd, s.we, s.err, 8'(s.cnt), hit};
   endfunction

   function automatic logic [48:0] got_a();
      return {out_valid_a, wb_data_a, wb_rd_a, wb_we_a, sel_err_a, err_count_a, fwd_hit_a};
   endfunction

   function automatic logic [48:0] got_b();
      return {out_valid_b, wb_data_b, wb_rd_b, wb_we_b, sel_err_b, err_count_b, fwd_hit_b};
   endfunction

   task automatic tick();
      @(posedge clk);
      ma = mstep(ma, int'(in_sel_a), 1'b0);
      mb = mstep(mb, int'(in_sel_b), 1'b1);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1; stall = 0; flush = 0; in_valid = 0; in_regwrite = 0;
      in_sel_a = 0; in_sel_b = 0; in_rd = 0; fwd_rs = 0;
      src[0] = 0; src[1] = 0; src[2] = 0;
      repeat (2) tick();
      n_checks++;
      if (got_a() !== 49'd0) $display("FAIL reset_a: got %h expected 0", got_a()); else n_pass++;
      n_checks++;
      if (got_b() !== 49'd0) $display("FAIL reset_b: got %h expected 0", got_b()); else n_pass++;
      reset = 0;
   endtask

   task automatic test_encoded_select();
      src[0] = 32'h11111111; src[1] = 32'h22222222; src[2] = 32'h00400008;
      in_sel_a = 2; in_sel_b = 3'b100; in_rd = 31; in_regwrite = 1; in_valid = 1; fwd_rs = 31;
      tick();
      n_checks++;
      if ({out_valid_a, wb_data_a, wb_rd_a, wb_we_a, fwd_hit_a} !== {1'b1, 32'h00400008, 5'd31, 1'b1, 1'b1})
         $display("FAIL encoded_sel: got %h expected %h",
                  {out_valid_a, wb_data_a, wb_rd_a, wb_we_a, fwd_hit_a}, {1'b1, 32'h00400008, 5'd31, 1'b1, 1'b1});
      else n_pass++;
      n_checks++;
      if (got_b() !== exp_of(mb)) $display("FAIL onehot_src2: got %h expected %h", got_b(), exp_of(mb)); else n_pass++;
      // Zero guard: write to r0 is suppressed and never forwards.
      src[0] = 32'hDEADBEEF; in_sel_a = 0; in_sel_b = 3'b000; in_rd = 0; fwd_rs = 0;
      tick();
      n_checks++;
      if ({wb_data_a, wb_we_a, fwd_hit_a} !== {32'hDEADBEEF, 1'b0, 1'b0})
         $display("FAIL zero_guard: got %h expected %h", {wb_data_a, wb_we_a, fwd_hit_a}, {32'hDEADBEEF, 1'b0, 1'b0});
      else n_pass++;
      n_checks++;
      if ({wb_data_b, wb_we_b} !== {32'hDEADBEEF, 1'b0})
         $display("FAIL onehot_zero_sel: got %h expected %h", {wb_data_b, wb_we_b}, {32'hDEADBEEF, 1'b0});
      else n_pass++;
   endtask

   task automatic test_illegal_select();
      in_sel_a = 1; in_sel_b = 3'b010; in_rd = 7; fwd_rs = 7;
      tick();
      in_sel_a = 3; in_sel_b = 3'b011;
      tick();
      n_checks++;
      if ({wb_data_a, wb_we_a, sel_err_a, err_count_a, out_valid_a} !== {32'h22222222, 1'b0, 1'b1, 8'd1, 1'b1})
         $display("FAIL illegal_first: got %h expected %h",
                  {wb_data_a, wb_we_a, sel_err_a, err_count_a, out_valid_a}, {32'h22222222, 1'b0, 1'b1, 8'd1, 1'b1});
      else n_pass++;
      n_checks++;
      if (got_b() !== exp_of(mb)) $display("FAIL illegal_first_b: got %h expected %h", got_b(), exp_of(mb)); else n_pass++;
      in_valid = 0;
      tick();
      n_checks++;
      if ({sel_err_a, err_count_a, wb_we_a} !== {1'b0, 8'd1, 1'b0})
         $display("FAIL illegal_novalid: got %h expected %h", {sel_err_a, err_count_a, wb_we_a}, {1'b0, 8'd1, 1'b0});
      else n_pass++;
      in_valid = 1;
      for (int i = 0; i < 300; i++) begin
         tick();
         n_checks++;
         if (got_a() !== exp_of(ma)) $display("FAIL sat_loop_a: got %h expected %h", got_a(), exp_of(ma)); else n_pass++;
      end
      n_checks++;
      if ({err_count_a, sel_err_a, err_count_b} !== {8'd255, 1'b1, 8'd255})
         $display("FAIL err_saturate: got %h expected %h", {err_count_a, sel_err_a, err_count_b}, {8'd255, 1'b1, 8'd255});
      else n_pass++;
   endtask

   task automatic test_onehot();
      in_sel_a = 1; in_sel_b = 3'b011; in_rd = 9; in_regwrite = 1; in_valid = 1;
      tick();
      n_checks++;
      if ({sel_err_b, wb_we_b} !== {1'b1, 1'b0})
         $display("FAIL onehot_conflict: got %h expected %h", {sel_err_b, wb_we_b}, {1'b1, 1'b0});
      else n_pass++;
      src[0] = 32'hA0A0A0A0; in_sel_b = 3'b000;
      tick();
      n_checks++;
      if ({wb_data_b, wb_we_b, sel_err_b} !== {32'hA0A0A0A0, 1'b1, 1'b0})
         $display("FAIL onehot_000: got %h expected %h", {wb_data_b, wb_we_b, sel_err_b}, {32'hA0A0A0A0, 1'b1, 1'b0});
      else n_pass++;
      src[2] = 32'hC0C0C0C0; in_sel_b = 3'b100;
      tick();
      n_checks++;
      if ({wb_data_b, wb_we_b} !== {32'hC0C0C0C0, 1'b1})
         $display("FAIL onehot_100: got %h expected %h", {wb_data_b, wb_we_b}, {32'hC0C0C0C0, 1'b1});
      else n_pass++;
   endtask

   task automatic test_stall_flush();
      src[0] = 32'h5; in_sel_a = 0; in_sel_b = 0; in_rd = 5; in_regwrite = 1; in_valid = 1;
      tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         src[0] = $urandom; src[1] = $urandom; in_rd = 5'($urandom);
         in_sel_a = 2'(i + 1); in_sel_b = 3'b011; in_valid = 1'($urandom);
         tick();
         n_checks++;
         if ({out_valid_a, wb_data_a, wb_rd_a, wb_we_a, sel_err_a, err_count_a} !==
             {1'b1, 32'h5, 5'd5, 1'b1, 1'b0, 8'd255})
            $display("FAIL stall_hold: got %h expected %h",
                     {out_valid_a, wb_data_a, wb_rd_a, wb_we_a, sel_err_a, err_count_a},
                     {1'b1, 32'h5, 5'd5, 1'b1, 1'b0, 8'd255});
         else n_pass++;
         n_checks++;
         if (got_b() !== exp_of(mb)) $display("FAIL stall_hold_b: got %h expected %h", got_b(), exp_of(mb)); else n_pass++;
      end
      flush = 1;
      tick();
      n_checks++;
      if ({out_valid_a, wb_we_a, wb_data_a, wb_rd_a} !== {1'b0, 1'b0, 32'h5, 5'd5})
         $display("FAIL stall_flush: got %h expected %h",
                  {out_valid_a, wb_we_a, wb_data_a, wb_rd_a}, {1'b0, 1'b0, 32'h5, 5'd5});
      else n_pass++;
      stall = 0; flush = 0;
   endtask

   task automatic test_reset_mid_stall();
      src[1] = 32'h77; in_sel_a = 1; in_sel_b = 3'b010; in_rd = 12; fwd_rs = 12; in_valid = 1;
      tick();
      stall = 1;
      tick();
      reset = 1;
      tick();
      n_checks++;
      if (got_a() !== 49'd0) $display("FAIL reset_mid_stall_a: got %h expected 0", got_a()); else n_pass++;
      n_checks++;
      if (got_b() !== 49'd0) $display("FAIL reset_mid_stall_b: got %h expected 0", got_b()); else n_pass++;
      reset = 0; stall = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         reset       = ($urandom_range(63) == 0);
         flush       = ($urandom_range(7) == 0);
         stall       = ($urandom_range(5) == 0);
         in_valid    = ($urandom_range(3) != 0);
         in_regwrite = ($urandom_range(4) != 0);
         in_sel_a    = 2'($urandom_range(3));
         in_sel_b    = 3'($urandom_range(7));
         in_rd       = 5'($urandom_range(7));
         fwd_rs      = 5'($urandom_range(7));
         for (int k = 0; k < 3; k++) src[k] = $urandom;
         tick();
         n_checks++;
         if (got_a() !== exp_of(ma)) $display("FAIL random_a: got %h expected %h", got_a(), exp_of(ma)); else n_pass++;
         n_checks++;
         if (got_b() !== exp_of(mb)) $display("FAIL random_b: got %h expected %h", got_b(), exp_of(mb)); else n_pass++;
      end
      reset = 0; flush = 0; stall = 0;
   endtask

   initial begin
      ma = '{default: 0};
      mb = '{default: 0};
      reset = 1; stall = 0; flush = 0; in_valid = 0; in_regwrite = 0;
      in_sel_a = 0; in_sel_b = 0; in_rd = 0; fwd_rs = 0;
      src[0] = 0; src[1] = 0; src[2] = 0;
      @(negedge clk);
      test_reset();
      test_encoded_select();
      test_illegal_select();
      test_onehot();
      test_stall_flush();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
